wb_regfile_stage: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory read data or ALU result) and commits it to a 16 x 24-bit register file.
- Serves two combinational read ports to decode, with same-cycle write-to-read bypass.
- Keeps a pending-write scoreboard that decode sets at issue and writeback clears, producing a stall for RAW/WAW hazards, plus a retired-writeback counter.

---
 rtl/wb_regfile_stage.sv | 94 +++++++++
 tb/tb_wb_regfile_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the commit value, writes a 16 x 24-bit register file with
// same-cycle read bypass, and tracks outstanding producers in a pending-write scoreboard.
module wb_regfile_stage #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   writeback_enable,
    input  logic                   mem_read_enable,
    input  logic [ADDR_WIDTH-1:0]  instruction_dest,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic [DATA_WIDTH-1:0]  rd_data_a,
    output logic [DATA_WIDTH-1:0]  rd_data_b,
    input  logic                   issue_valid,
    input  logic [ADDR_WIDTH-1:0]  issue_dest,
    output logic                   pending_a,
    output logic                   pending_b,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  wb_data,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
    logic [NUM_REGS-1:0]    pend;
    logic [NUM_REGS-1:0]    pend_next;
    logic [COUNT_WIDTH-1:0] count_q;

    logic wb_hit_a;
    logic wb_hit_b;
    logic wb_hit_issue;
    logic waw;
    logic issue_set;

    assign wb_data       = mem_read_enable ? mem_read_data : alu_result;
    assign retired_count = count_q;

    // A writeback this cycle to the same index satisfies that consumer immediately.
    assign wb_hit_a     = writeback_enable && (instruction_dest == rd_addr_a);
    assign wb_hit_b     = writeback_enable && (instruction_dest == rd_addr_b);
    assign wb_hit_issue = writeback_enable && (instruction_dest == issue_dest);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rd_data_a = '0;
        rd_data_b = '0;
        if (!rst && rd_addr_a != '0)
            rd_data_a = wb_hit_a ? wb_data : regs[rd_addr_a];
        if (!rst && rd_addr_b != '0)
            rd_data_b = wb_hit_b ? wb_data : regs[rd_addr_b];
    end

    always_comb begin
        pending_a = !rst && pend[rd_addr_a] && !wb_hit_a;
        pending_b = !rst && pend[rd_addr_b] && !wb_hit_b;
        waw       = pend[issue_dest] && !wb_hit_issue && (issue_dest != '0);
        stall     = !rst && issue_valid && (pending_a || pending_b || waw);
        issue_set = issue_valid && !stall && (issue_dest != '0);
    end

    // Clear from writeback first, then set from issue, so a new producer wins on collision.
    always_comb begin
        pend_next = pend;
        if (writeback_enable)
            pend_next[instruction_dest] = 1'b0;
        if (issue_set)
            pend_next[issue_dest] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register array is reset explicitly because architected state must read 0 after reset.
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pend    <= '0;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
            if (writeback_enable && instruction_dest != '0)
                regs[instruction_dest] <= wb_data;
            pend <= pend_next;
            if (writeback_enable)
                count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: a vector table fed through an expectation
// queue, plus hand-written sequences for reset, mid-run reset and counter wrap.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic        writeback_enable = 1'b0;
    logic        mem_read_enable = 1'b0;
    logic [3:0]  instruction_dest = '0;
    logic [23:0] mem_read_data = '0;
    logic [23:0] alu_result = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [23:0] rd_data_a;
    logic [23:0] rd_data_b;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_dest = '0;
    logic        pending_a;
    logic        pending_b;
    logic        stall;
    logic [23:0] wb_data;
    logic [15:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile_stage dut (
        .clk              (clk),
        .rst              (rst),
        .writeback_enable (writeback_enable),
        .mem_read_enable  (mem_read_enable),
        .instruction_dest (instruction_dest),
        .mem_read_data    (mem_read_data),
        .alu_result       (alu_result),
        .rd_addr_a        (rd_addr_a),
        .rd_addr_b        (rd_addr_b),
        .rd_data_a        (rd_data_a),
        .rd_data_b        (rd_data_b),
        .issue_valid      (issue_valid),
        .issue_dest       (issue_dest),
        .pending_a        (pending_a),
        .pending_b        (pending_b),
        .stall            (stall),
        .wb_data          (wb_data),
        .retired_count    (retired_count)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic        we;
        logic        mre;
        logic [3:0]  dest;
        logic [23:0] mem;
        logic [23:0] alu;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        iv;
        logic [3:0]  idest;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
        logic [23:0] exp_wb;
        logic        exp_pa;
        logic        exp_pb;
        logic        exp_stall;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [16];
    vec_t exp_q [$];

    function automatic vec_t mk(input logic we, input logic mre, input logic [3:0] dest,
                                input logic [23:0] mem, input logic [23:0] alu,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic iv, input logic [3:0] idest,
                                input logic [23:0] ea, input logic [23:0] eb, input logic [23:0] ewb,
                                input logic epa, input logic epb, input logic est,
                                input logic [15:0] ecnt);
        vec_t v;
        v.we = we; v.mre = mre; v.dest = dest; v.mem = mem; v.alu = alu;
        v.ra = ra; v.rb = rb; v.iv = iv; v.idest = idest;
        v.exp_a = ea; v.exp_b = eb; v.exp_wb = ewb;
        v.exp_pa = epa; v.exp_pb = epb; v.exp_stall = est; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic mre, input logic [3:0] dest,
                         input logic [23:0] mem, input logic [23:0] alu,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic iv, input logic [3:0] idest);
        writeback_enable = we;
        mem_read_enable  = mre;
        instruction_dest = dest;
        mem_read_data    = mem;
        alu_result       = alu;
        rd_addr_a        = ra;
        rd_addr_b        = rb;
        issue_valid      = iv;
        issue_dest       = idest;
    endtask

    // Drive one vector just after an edge, queue its expectations, compare mid-cycle, then clock.
    task automatic apply(input int idx);
        vec_t v;
        vec_t e;
        v = tbl[idx];
        drive(v.we, v.mre, v.dest, v.mem, v.alu, v.ra, v.rb, v.iv, v.idest);
        exp_q.push_back(v);
        #3;
        e = exp_q.pop_front();
        check($sformatf("v%0d rd_data_a", idx), 32'(rd_data_a), 32'(e.exp_a));
        check($sformatf("v%0d rd_data_b", idx), 32'(rd_data_b), 32'(e.exp_b));
        check($sformatf("v%0d wb_data", idx), 32'(wb_data), 32'(e.exp_wb));
        check($sformatf("v%0d pending_a", idx), 32'(pending_a), 32'(e.exp_pa));
        check($sformatf("v%0d pending_b", idx), 32'(pending_b), 32'(e.exp_pb));
        check($sformatf("v%0d stall", idx), 32'(stall), 32'(e.exp_stall));
        check($sformatf("v%0d retired_count", idx), 32'(retired_count), 32'(e.exp_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          we mre dest mem        alu         ra rb iv id  exp_a      exp_b      exp_wb     pa pb st cnt
        tbl[0]  = mk(1, 0, 1, 24'h55,     24'h1,      1, 0, 0, 0, 24'h1,     24'h0,     24'h1,     0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 2, 24'h2,      24'h77,     1, 2, 0, 0, 24'h1,     24'h2,     24'h2,     0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 3, 24'h99,     24'h3,      2, 3, 0, 0, 24'h2,     24'h3,     24'h3,     0, 0, 0, 2);
        tbl[3]  = mk(0, 1, 3, 24'h123456, 24'h0,      3, 1, 0, 0, 24'h3,     24'h1,     24'h123456, 0, 0, 0, 3);
        tbl[4]  = mk(1, 0, 4, 24'h0,      24'hABCDEF, 4, 3, 0, 0, 24'hABCDEF, 24'h3,    24'hABCDEF, 0, 0, 0, 3);
        tbl[5]  = mk(1, 0, 0, 24'h0,      24'h7,      0, 4, 0, 0, 24'h0,     24'hABCDEF, 24'h7,    0, 0, 0, 4);
        tbl[6]  = mk(0, 0, 0, 24'h0,      24'h0,      0, 0, 1, 6, 24'h0,     24'h0,     24'h0,     0, 0, 0, 5);
        tbl[7]  = mk(0, 0, 0, 24'h0,      24'h0,      4, 6, 1, 8, 24'hABCDEF, 24'h0,    24'h0,     0, 1, 1, 5);
        tbl[8]  = mk(1, 0, 6, 24'h0,      24'h666,    0, 6, 1, 8, 24'h0,     24'h666,   24'h666,   0, 0, 0, 5);
        tbl[9]  = mk(0, 0, 0, 24'h0,      24'h0,      6, 8, 0, 0, 24'h666,   24'h0,     24'h0,     0, 1, 0, 6);
        tbl[10] = mk(0, 0, 0, 24'h0,      24'h0,      0, 0, 1, 7, 24'h0,     24'h0,     24'h0,     0, 0, 0, 6);
        tbl[11] = mk(0, 0, 0, 24'h0,      24'h0,      0, 0, 1, 7, 24'h0,     24'h0,     24'h0,     0, 0, 1, 6);
        tbl[12] = mk(1, 0, 7, 24'h0,      24'h777,    0, 0, 1, 7, 24'h0,     24'h0,     24'h777,   0, 0, 0, 6);
        tbl[13] = mk(0, 0, 0, 24'h0,      24'h0,      7, 8, 0, 0, 24'h777,   24'h0,     24'h0,     1, 1, 0, 7);
        tbl[14] = mk(1, 0, 5, 24'h0,      24'h50505,  5, 2, 1, 0, 24'h50505, 24'h2,     24'h50505, 0, 0, 0, 7);
        tbl[15] = mk(0, 0, 0, 24'h0,      24'h0,      5, 0, 1, 3, 24'h50505, 24'h0,     24'h0,     0, 0, 0, 8);

        // Reset with the clock idle: outputs must clear without any edge.
        drive(1, 0, 4, 24'h0, 24'h123, 4, 4, 1, 4);
        #3 rst = 1'b1;
        #1;
        check("reset rd_data_a", 32'(rd_data_a), 32'h0);
        check("reset rd_data_b", 32'(rd_data_b), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset retired_count", 32'(retired_count), 32'h0);
        drive(0, 0, 0, 24'h0, 24'h0, 5, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("post-reset rd_data_a R5", 32'(rd_data_a), 32'h0);
        check("post-reset retired_count", 32'(retired_count), 32'h0);
        check("post-reset pending_a", 32'(pending_a), 32'h0);
        clk_run = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            apply(i);
        check("table end retired_count", 32'(retired_count), 32'd8);

        // Mid-run reset between edges with pending bits 3, 7, 8 outstanding.
        drive(1, 0, 4, 24'h0, 24'h444, 4, 7, 1, 7);
        #2 rst = 1'b1;
        #1;
        check("midreset bypass off", 32'(rd_data_a), 32'h0);
        check("midreset pending_b", 32'(pending_b), 32'h0);
        check("midreset stall", 32'(stall), 32'h0);
        check("midreset retired_count", 32'(retired_count), 32'h0);
        drive(0, 0, 0, 24'h0, 24'h0, 3, 7, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("midreset R3 cleared", 32'(rd_data_a), 32'h0);
        check("midreset pend7 cleared", 32'(pending_b), 32'h0);
        drive(0, 0, 0, 24'h0, 24'h0, 0, 8, 1, 3);
        #1;
        check("midreset pend8/pend3 cleared", 32'(stall), 32'h0);

        // First commit after release uses the inputs present at that edge.
        drive(1, 0, 2, 24'h0, 24'hAA, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 24'h0, 24'h0, 2, 0, 0, 0);
        #1;
        check("first commit R2", 32'(rd_data_a), 32'hAA);
        check("first commit retired_count", 32'(retired_count), 32'd1);

        // Counter wrap: bring the count to 65535 with R0 writebacks, then one more.
        drive(1, 0, 0, 24'h0, 24'h1, 0, 0, 0, 0);
        repeat (65534) @(posedge clk);
        #1;
        check("count max", 32'(retired_count), 32'hFFFF);
        @(posedge clk);
        #1;
        check("count wrap", 32'(retired_count), 32'h0);
        drive(0, 0, 0, 24'h0, 24'h0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
